// File: rtl/gate_truth_checker.sv
// Drives all four {a,b} vectors into a two-input gate, samples z after a
// settle window and scores it against the EXPECT truth table.
module gate_truth_checker #(
    parameter int         SETTLE = 4,
    parameter logic [3:0] EXPECT = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_mask
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] LP_LOAD = 4'(SETTLE - 1);

    state_t     r_state;
    logic [1:0] r_vec;
    logic [3:0] r_cnt;

    logic       w_miss;
    logic [2:0] w_err_next;
    logic [1:0] w_vec_next;

    assign w_miss     = (z != EXPECT[r_vec]);
    assign w_err_next = err_cnt + 3'(w_miss);
    assign w_vec_next = r_vec + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_vec     <= 2'd0;
            r_cnt     <= 4'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= 3'd0;
            fail_mask <= 4'd0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    a <= 1'b0;
                    b <= 1'b0;
                    if (start) begin
                        err_cnt   <= 3'd0;
                        fail_mask <= 4'd0;
                        pass      <= 1'b0;
                        r_vec     <= 2'd0;
                        r_cnt     <= LP_LOAD;
                        busy      <= 1'b1;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (w_miss) begin
                        err_cnt          <= w_err_next;
                        fail_mask[r_vec] <= 1'b1;
                    end
                    if (r_vec == 2'd3) begin
                        // Verdict must include this last sample, so use the next count.
                        pass    <= (w_err_next == 3'd0);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_vec   <= w_vec_next;
                        a       <= w_vec_next[1];
                        b       <= w_vec_next[0];
                        r_cnt   <= LP_LOAD;
                        r_state <= S_WAIT;
                    end
                end
                S_DONE: begin
                    a       <= 1'b0;
                    b       <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench: AND/NAND/stuck models on the default checker, XOR with
// fast and slow gate delay on a SETTLE=1 checker.
module tb_gate_truth_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       a0, b0, z0, busy0, done0, pass0;
    logic       a1, b1, z1, busy1, done1, pass1;
    logic [2:0] err0, err1;
    logic [3:0] fm0, fm1;
    logic [1:0] mode = 2'd0;
    logic       slow = 1'b0;
    logic       zf, zs;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign #1 z0 = (mode == 2'd0) ? (a0 & b0) :
                   (mode == 2'd1) ? ~(a0 & b0) :
                   (mode == 2'd2) ? 1'b0 : 1'b1;

    assign #1  zf = a1 ^ b1;
    assign #25 zs = a1 ^ b1;
    assign z1 = slow ? zs : zf;

    gate_truth_checker u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .a(a0), .b(b0), .z(z0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .fail_mask(fm0)
    );

    gate_truth_checker #(.SETTLE(1), .EXPECT(4'b0110)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a(a1), .b(b1), .z(z1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .fail_mask(fm1)
    );

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic run0(input logic [1:0] m, input bit poke,
                        output int lat);
        mode = m;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("clr0", {pass0, err0, fm0}, 8'h00);
        chk("busy0", 8'(busy0), 8'd1);
        lat = 0;
        while (!done0 && lat < 100) begin
            if (lat % 5 == 2 && lat < 20)
                chk("ab0", 8'({a0, b0}), 8'(lat / 5));
            start0 = poke && (lat == 8);
            @(negedge clk);
            lat++;
        end
        start0 = poke;
        @(negedge clk);
        start0 = 1'b0;
        chk("end0", 8'({done0, busy0}), 8'd0);
    endtask

    task automatic run1(input logic s, output int lat);
        slow = s;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 100) begin
            if (lat % 2 == 0 && lat < 8)
                chk("ab1", 8'({a1, b1}), 8'(lat / 2));
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        chk("end1", 8'({done1, busy1}), 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        bit seen;
        repeat (3) @(negedge clk);
        chk("rst0", {a0, b0, busy0, done0, pass0, err0}, 8'h00);
        chk("rst0m", 8'(fm0), 8'h00);
        chk("rst1", {a1, b1, busy1, done1, pass1, err1}, 8'h00);
        rst = 1'b0;

        run0(2'd0, 1'b0, lat);
        chk("lat_and", 8'(lat), 8'd20);
        chk("and", {pass0, err0, fm0}, {1'b1, 3'd0, 4'b0000});
        run0(2'd1, 1'b0, lat);
        chk("nand", {pass0, err0, fm0}, {1'b0, 3'd4, 4'b1111});
        run0(2'd2, 1'b0, lat);
        chk("sa0", {pass0, err0, fm0}, {1'b0, 3'd1, 4'b1000});
        run0(2'd3, 1'b0, lat);
        chk("sa1", {pass0, err0, fm0}, {1'b0, 3'd3, 4'b0111});

        mode = 2'd1;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (11) @(negedge clk);
        chk("pre_rst", {a0, b0, busy0, done0, pass0, err0},
            {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2});
        #1 rst = 1'b1;
        #1;
        chk("arst", {a0, b0, busy0, done0, pass0, err0}, 8'h00);
        chk("arstm", 8'(fm0), 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done0 || busy0) seen = 1'b1;
        end
        chk("nodone", 8'(seen), 8'd0);
        run0(2'd0, 1'b0, lat);
        chk("restart", {pass0, err0, fm0}, {1'b1, 3'd0, 4'b0000});

        run0(2'd0, 1'b1, lat);
        chk("lat_poke", 8'(lat), 8'd20);
        chk("poke", {pass0, err0, fm0}, {1'b1, 3'd0, 4'b0000});

        run1(1'b0, lat);
        chk("lat_xor", 8'(lat), 8'd8);
        chk("xor", {pass1, err1, fm1}, {1'b1, 3'd0, 4'b0000});
        run1(1'b1, lat);
        chk("xor_slow", {pass1, err1, fm1}, {1'b0, 3'd2, 4'b1010});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
